// File: rtl/aes_cipher_iter_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the iterative AES-128 cipher.
package aes_cipher_iter_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned NR      = 10;
    localparam int unsigned KEYS_W  = 1408;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    // Bytes are column-major (index = row + 4*col); ShiftRows rotates row r left by r columns.
    function automatic logic [3:0] shift_rows_src(logic [3:0] idx);
        logic [1:0] row;
        logic [1:0] src_col;
        row     = idx[1:0];
        src_col = idx[3:2] + row;
        return {src_col, row};
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] aa;
        prod = 8'h00;
        aa   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ aa;
            end
            aa = xtime(aa);
        end
        return prod;
    endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Block handshake bundle between the upstream key schedule / source and the cipher core.
interface aes_cipher_iter_if;
    import aes_cipher_iter_pkg::*;

    logic               inValid;
    logic               inReady;
    logic [BLOCK_W-1:0] plainIn;
    logic [KEYS_W-1:0]  keysIn;
    logic               outValid;
    logic               outReady;
    logic [BLOCK_W-1:0] cipherOut;
    logic               busy;

    modport master (
        output inValid, plainIn, keysIn, outReady,
        input  inReady, outValid, cipherOut, busy
    );

    modport slave (
        input  inValid, plainIn, keysIn, outReady,
        output inReady, outValid, cipherOut, busy
    );

endinterface

// File: rtl/aes_cipher_iter_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_cipher_iter_round
    import aes_cipher_iter_pkg::*;
(
    input  logic [BLOCK_W-1:0] stateIn,
    input  logic [BLOCK_W-1:0] roundKey,
    input  logic               lastRound,
    output logic [BLOCK_W-1:0] stateOut
);

    logic [7:0] in_b  [16];
    logic [7:0] sub_b [16];
    logic [7:0] shr_b [16];
    logic [7:0] mix_b [16];

    // Byte 0 is the most significant byte of the block.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            in_b[i] = stateIn[BLOCK_W-1-8*i -: 8];
        end
    end

    for (genvar g = 0; g < 16; g++) begin : gen_sbox
        aes_sbox u_sbox (
            .data  (in_b[g]),
            .subst (sub_b[g])
        );
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            shr_b[i] = sub_b[shift_rows_src(4'(i))];
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mix_b[4*c]   = xtime(shr_b[4*c]) ^ xtime(shr_b[4*c+1]) ^ shr_b[4*c+1]
                         ^ shr_b[4*c+2] ^ shr_b[4*c+3];
            mix_b[4*c+1] = shr_b[4*c] ^ xtime(shr_b[4*c+1]) ^ xtime(shr_b[4*c+2])
                         ^ shr_b[4*c+2] ^ shr_b[4*c+3];
            mix_b[4*c+2] = shr_b[4*c] ^ shr_b[4*c+1] ^ xtime(shr_b[4*c+2])
                         ^ xtime(shr_b[4*c+3]) ^ shr_b[4*c+3];
            mix_b[4*c+3] = xtime(shr_b[4*c]) ^ shr_b[4*c] ^ shr_b[4*c+1]
                         ^ shr_b[4*c+2] ^ xtime(shr_b[4*c+3]);
        end
    end

    always_comb begin
        stateOut = '0;
        for (int i = 0; i < 16; i++) begin
            stateOut[BLOCK_W-1-8*i -: 8] = (lastRound ? shr_b[i] : mix_b[i])
                                         ^ roundKey[BLOCK_W-1-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox
    import aes_cipher_iter_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] subst
);

    logic [7:0] inv;

    // x^254 = x^-1 (and 0 -> 0), built as the product of x^2, x^4, ..., x^128.
    always_comb begin
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = data;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        inv = acc;
    end

    assign subst = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption core, one round per clock, valid/ready on input and output.
// Define AES_CIPHER_KEY_LATCH_EN to capture keysIn on acceptance so it may change afterwards.
module aes_cipher_iter #(
    parameter int unsigned NR = aes_cipher_iter_pkg::NR
) (
    input logic              clk,
    input logic              rstN,
    aes_cipher_iter_if.slave bus
);
    import aes_cipher_iter_pkg::*;

    localparam logic [3:0] LastRound = 4'(NR);

    state_e                   fsm_q, fsm_d;
    logic [BLOCK_W-1:0]       data_q, data_d;
    logic [3:0]               round_q, round_d;
    logic [NR:0][BLOCK_W-1:0] round_keys;
    logic [BLOCK_W-1:0]       round_key;
    logic [BLOCK_W-1:0]       round_out;
    logic                     last_round;
    logic                     accept;

    assign accept     = (fsm_q == IDLE) && bus.inValid;
    assign last_round = (round_q == LastRound);

`ifdef AES_CIPHER_KEY_LATCH_EN
    logic [KEYS_W-1:0] key_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            key_q <= '0;
        end else if (accept) begin
            key_q <= bus.keysIn;
        end
    end

    assign round_keys = key_q;
`else
    assign round_keys = bus.keysIn;
`endif

    assign round_key = round_keys[round_q];

    aes_cipher_iter_round u_round (
        .stateIn   (data_q),
        .roundKey  (round_key),
        .lastRound (last_round),
        .stateOut  (round_out)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (accept) fsm_d = ROUND;
            ROUND:   if (last_round) fsm_d = DONE;
            DONE:    if (bus.outReady) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        bus.inReady  = 1'b0;
        bus.outValid = 1'b0;
        bus.busy     = 1'b0;
        unique case (fsm_q)
            IDLE:  bus.inReady = 1'b1;
            ROUND: bus.busy    = 1'b1;
            DONE: begin
                bus.outValid = 1'b1;
                bus.busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // The initial whitening always uses key 0 straight from the port: it happens on the accept edge.
    always_comb begin
        data_d  = data_q;
        round_d = round_q;
        unique case (fsm_q)
            IDLE: begin
                round_d = '0;
                if (accept) begin
                    data_d  = bus.plainIn ^ bus.keysIn[BLOCK_W-1:0];
                    round_d = 4'd1;
                end
            end
            ROUND: begin
                data_d = round_out;
                if (!last_round) begin
                    round_d = round_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            data_q  <= '0;
            round_q <= '0;
        end else begin
            data_q  <= data_d;
            round_q <= round_d;
        end
    end

    assign bus.cipherOut = data_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Scoreboard bench for aes_cipher_iter against a byte-level AES-128 reference model.
// Honours AES_CIPHER_KEY_LATCH_EN when choosing the expected result of the key-change block.
module tb_aes_cipher_iter;
    import aes_cipher_iter_pkg::*;

    typedef logic [10:0][127:0] rkeys_t;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rstN;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [127:0] exp_q [$];
    int           acc_q [$];
    logic [127:0] next_exp = '0;
    logic         ov_prev = 1'b0;
    logic [7:0]   sbox_t [256];
    logic [7:0]   aff_c = 8'h63;

    aes_cipher_iter_if bus ();

    aes_cipher_iter #(.NR(NR)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic rkeys_t expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rkeys_t      rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input rkeys_t rk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row+4*c] = sbox_t[s[row+4*((c+row)%4)]];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Acceptance: record the expected result and the accept edge number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstN && bus.inValid && bus.inReady) begin
            exp_q.push_back(next_exp);
            acc_q.push_back(cyc + 1);
        end
    end

    // Output monitor: check each new ciphertext and its latency.
    always @(negedge clk) begin
        if (rstN && bus.outValid && !ov_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", bus.outValid, 1'b0);
            end else begin
                chk("ciphertext", bus.cipherOut, exp_q[0]);
                chk("latency", 128'(cyc - acc_q[0]), 128'd10);
                exp_q.delete(0);
                acc_q.delete(0);
            end
        end
        ov_prev <= bus.outValid;
    end

    task automatic send(input logic [127:0] pt, input rkeys_t keys, input logic [127:0] e);
        int n;
        n = 0;
        while (bus.inReady !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_before_send", bus.inReady, 1'b1);
        bus.plainIn = pt;
        bus.keysIn  = keys;
        next_exp    = e;
        bus.inValid = 1'b1;
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.inReady !== 1'b1) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rkeys_t       kb, kc, kr, kz;
        logic [127:0] pt, e;
        logic [7:0]   inv, b;
        logic         rdy;
        int           n, acc, last_acc;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff_c[i];
            sbox_t[x] = b;
        end

        rstN         = 1'b1;
        bus.inValid  = 1'b0;
        bus.plainIn  = '0;
        bus.keysIn   = '0;
        bus.outReady = 1'b0;
        #1 rstN = 1'b0;
        #1;
        chk("reset_in_ready", bus.inReady, 1'b1);
        chk("reset_out_valid", bus.outValid, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_cipher", bus.cipherOut, '0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        kb = expand(KEY_B);
        kc = expand(KEY_C);
        bus.outReady = 1'b1;
        send(PT_B, kb, CT_B);
        drain();
        send(PT_C, kc, CT_C);
        drain();

        // Random keys and plaintexts with a random stall in DONE.
        for (int k = 0; k < 6; k++) begin
            kr = expand({$urandom, $urandom, $urandom, $urandom});
            pt = {$urandom, $urandom, $urandom, $urandom};
            bus.outReady = 1'b0;
            send(pt, kr, ref_encrypt(pt, kr));
            repeat ($urandom_range(8, 16)) @(posedge clk);
            #1;
            bus.outReady = 1'b1;
            drain();
        end

        // Backpressure with a concurrent inValid that must be ignored.
        bus.outReady = 1'b0;
        send(PT_B, kb, CT_B);
        n = 0;
        while (bus.outValid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid", bus.outValid, 1'b1);
        bus.plainIn = PT_C;
        bus.keysIn  = kc;
        next_exp    = CT_C;
        bus.inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_cipher_stable", bus.cipherOut, CT_B);
            chk("bp_in_ready_low", bus.inReady, 1'b0);
        end
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", bus.inReady, 1'b1);
        chk("bp_release_out_valid", bus.outValid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_extra_block", bus.busy, 1'b0);
        drain();

        // Back-to-back: inValid held high, one block every 12 cycles.
        bus.keysIn = kb;
        last_acc   = 0;
        for (int k = 0; k < 4; k++) begin
            pt          = {$urandom, $urandom, $urandom, $urandom};
            bus.plainIn = pt;
            next_exp    = ref_encrypt(pt, kb);
            bus.inValid = 1'b1;
            n = 0;
            do begin
                rdy = bus.inReady;
                @(posedge clk);
                #1;
                n++;
            end while (!rdy && n < 40);
            chk("b2b_accept", rdy, 1'b1);
            acc = cyc;
            if (k > 0) chk("b2b_period", 128'(acc - last_acc), 128'd12);
            last_acc = acc;
        end
        bus.inValid = 1'b0;
        drain();

        // Reset during round 5 aborts the block.
        send(PT_B, kb, CT_B);
        repeat (4) @(posedge clk);
        #3;
        rstN = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("midrst_in_ready", bus.inReady, 1'b1);
        chk("midrst_out_valid", bus.outValid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_cipher", bus.cipherOut, '0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        send(PT_B, kb, CT_B);
        drain();

        // Keys zeroed one cycle after acceptance.
`ifdef AES_CIPHER_KEY_LATCH_EN
        e = CT_B;
`else
        kz = kb;
        for (int r = 2; r < 11; r++) kz[r] = '0;
        e = ref_encrypt(PT_B, kz);
`endif
        send(PT_B, kb, e);
        @(posedge clk);
        #1;
        bus.keysIn = '0;
        drain();
        bus.keysIn = kb;

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
